sram: RTL and testbench
=======================

# sram

Single-port controller for an external asynchronous 256K x 16 SRAM. It turns one-cycle read/write requests from on-chip logic into correctly sequenced CS/OE/WE strobes, address pins and data pins. It reports completion through `ready` and returns read data in a register. It sits between the user logic and the top-level pad ring. The top level owns the bidirectional data tri-state.

## Interface
- `WAIT_CYCLES`, default 2: number of cycles the WE pulse (write) or OE access window (read) is held; minimum 1.

- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `address` in 18: word address of the request.
- `data_write` in 16: write data.
- `write` in 1: write request, level-sampled.
- `read` in 1: read request, level-sampled.
- `ready` out 1: high when idle and able to accept a request.
- `data_read` out 16: registered read result.
- `data_pins_out` out 16: data driven to SRAM; top level enables its pad driver while `WE` is low.
- `data_pins_in` in 16: data from SRAM pads.
- `address_pins` out 18: registered SRAM address.
- `CS` out 1: chip select, active low.
- `OE` out 1: output enable, active low.
- `WE` out 1: write enable, active low.

## Operation
- FSM states:
  - IDLE
  - W_SETUP
  - W_PULSE
  - W_HOLD
  - R_ACCESS
- Reset (any state) sets:
  - state to IDLE.
  - `CS`=`OE`=`WE`=1, `ready`=1.
  - `data_read`=0, `address_pins`=0, `data_pins_out`=0.
  - the wait counter to 0.
- Request acceptance:
  - A request is accepted on a clock edge only in IDLE.
  - Accepting latches `address` into `address_pins`.
  - A write also latches `data_write` into `data_pins_out`.
  - `write` and `read` high together: write wins; the read is dropped.
  - Requests outside IDLE are ignored, not queued.
  - A request level still high when IDLE is re-entered starts a new operation. Callers must drop it once `ready` falls.
- Write sequence:
  - W_SETUP, 1 cycle: `CS`=0, `WE`=1; address/data stable.
  - W_PULSE, `WAIT_CYCLES` cycles: `CS`=0, `WE`=0.
  - W_HOLD, 1 cycle: `CS`=0, `WE`=1; data still driven.
  - Then IDLE.
  - `OE`=1 throughout.
- Read sequence:
  - R_ACCESS, `WAIT_CYCLES` cycles: `CS`=0, `OE`=0, `WE`=1.
  - On the final R_ACCESS edge, `data_pins_in` is captured into `data_read`, then IDLE.
- `data_read` holds its value until the next read completes. Writes never alter it.
- `address_pins` and `data_pins_out` hold their last values while idle.
- `ready` is high exactly when state is IDLE.
- All SRAM-facing outputs are registered; no combinational path from request inputs to pins.

## Timing
- Write accepted at edge k:
  - `ready` low from k.
  - `WE` low during cycles k+1 .. k+WAIT_CYCLES.
  - `ready` high again after edge k+WAIT_CYCLES+2.
- Read accepted at edge k:
  - `OE`/`CS` low from k.
  - `data_read` valid and `ready` high after edge k+WAIT_CYCLES.
- `WE` and `OE` are never low simultaneously.
- `WE` never falls in the same cycle that address/data change.
- Reset mid-write or mid-read: all strobes return high on the next edge.
  - An aborted read does not update `data_read`.
  - `ready`=1 the cycle after reset deasserts.
- Back-to-back operations: minimum one IDLE cycle between them, all strobes high.

## Structure
- Shared package: FSM state enum; address width 18; data width 16; strobe inactive level constant.
- One natural sub-module: `sram_wait_counter`, a down-counter loaded with `WAIT_CYCLES` that asserts `done`. It is shared by the W_PULSE and R_ACCESS states.

## Test plan
- Reset pulse -> `CS`=`OE`=`WE`=1, `ready`=1, `data_read`=0x0000.
- Write addr 0x00000, data 0xAAAA, `write` held 3 cycles:
  - `data_pins_out`=0xAAAA and `address_pins`=0 before `WE` falls.
  - `WE` low exactly 2 cycles, `OE` stays high.
  - `ready` returns after 4 cycles; exactly one write performed.
- Read addr 0x00000 with pads driving 0x0A0A -> `OE` low 2 cycles, `data_read`=0x0A0A, `ready` high 2 cycles after accept.
- `write`=`read`=1 in IDLE (addr 0x3FFFF, data 0x1234) -> write sequence only, `address_pins`=0x3FFFF, `OE` never low, `data_read` unchanged.
- Request issued while busy -> ignored; strobes follow the original operation only.
- Reset asserted during W_PULSE -> `WE`, `CS` high next edge, FSM in IDLE, `ready`=1 after reset release.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the asynchronous SRAM controller.
package sram_pkg;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 16;

  // SRAM strobes are active low; this is their idle level.
  localparam logic STROBE_OFF = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_PULSE,
    W_HOLD,
    R_ACCESS
  } state_t;

endpackage

// File: rtl/sram_if.sv
// User-side request bus of the SRAM controller.
interface sram_if;
  import sram_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_write;
  logic              write;
  logic              read;
  logic              ready;
  logic [DATA_W-1:0] data_read;

  modport master (
    output address, data_write, write, read,
    input  ready, data_read
  );

  modport slave (
    input  address, data_write, write, read,
    output ready, data_read
  );

endinterface

// File: rtl/sram_wait_counter.sv
// Down-counter timing the WE pulse and the OE access window.
module sram_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(WAIT_CYCLES);
    end else if (en && count != '0) begin
      count <= count - CW'(1);
    end
  end

  // The edge that sees count==1 is the last one of the window.
  assign done = (count == CW'(1));

endmodule

// File: rtl/sram.sv
// Sequences CS/OE/WE, address and data pins for a 256K x 16 asynchronous SRAM.
module sram
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  sram_if.slave             bus,
  output logic [DATA_W-1:0] data_pins_out,
  input  logic [DATA_W-1:0] data_pins_in,
  output logic [ADDR_W-1:0] address_pins,
  output logic              CS,
  output logic              OE,
  output logic              WE
);

  state_t            state;
  logic              ready_q;
  logic [DATA_W-1:0] data_read_q;
  logic              cnt_load;
  logic              cnt_en;
  logic              cnt_done;

  // Reads start counting at acceptance; writes only once the setup cycle ends.
  assign cnt_load = (state == IDLE && !bus.write && bus.read) || (state == W_SETUP);
  assign cnt_en   = (state == W_PULSE) || (state == R_ACCESS);

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .en    (cnt_en),
    .done  (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      CS            <= STROBE_OFF;
      OE            <= STROBE_OFF;
      WE            <= STROBE_OFF;
      ready_q       <= 1'b1;
      data_read_q   <= '0;
      address_pins  <= '0;
      data_pins_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.write) begin
            state         <= W_SETUP;
            address_pins  <= bus.address;
            data_pins_out <= bus.data_write;
            CS            <= ~STROBE_OFF;
            ready_q       <= 1'b0;
          end else if (bus.read) begin
            state        <= R_ACCESS;
            address_pins <= bus.address;
            CS           <= ~STROBE_OFF;
            OE           <= ~STROBE_OFF;
            ready_q      <= 1'b0;
          end
        end
        W_SETUP: begin
          state <= W_PULSE;
          WE    <= ~STROBE_OFF;
        end
        W_PULSE: begin
          if (cnt_done) begin
            state <= W_HOLD;
            WE    <= STROBE_OFF;
          end
        end
        W_HOLD: begin
          state   <= IDLE;
          CS      <= STROBE_OFF;
          ready_q <= 1'b1;
        end
        R_ACCESS: begin
          if (cnt_done) begin
            state       <= IDLE;
            data_read_q <= data_pins_in;
            CS          <= STROBE_OFF;
            OE          <= STROBE_OFF;
            ready_q     <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          CS      <= STROBE_OFF;
          OE      <= STROBE_OFF;
          WE      <= STROBE_OFF;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.data_read = data_read_q;

endmodule

// File: tb/tb_sram.sv
// Scoreboard bench for the SRAM controller with a behavioural external SRAM.
module tb_sram;
  import sram_pkg::*;

  localparam int unsigned WAIT = 2;

  typedef struct {
    bit          is_write;
    logic [17:0] addr;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data_pins_out;
  logic [15:0] data_pins_in = '0;
  logic [17:0] address_pins;
  logic        CS, OE, WE;

  sram_if bus ();

  sram #(
    .WAIT_CYCLES (WAIT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .data_pins_out (data_pins_out),
    .data_pins_in  (data_pins_in),
    .address_pins  (address_pins),
    .CS            (CS),
    .OE            (OE),
    .WE            (WE)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sbq[$];
  logic [15:0] ref_mem[logic [17:0]];
  logic [15:0] dev_mem[logic [17:0]];
  bit          pad_force = 0;
  logic [15:0] pad_value = '0;
  bit          abort = 0;
  int          exp_writes = 0;
  int          n_we_pulses = 0;
  int          n_oe_falls = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Power-up contents of the external device for never-written words.
  function automatic logic [15:0] init_word(logic [17:0] a);
    return a[15:0] ^ {a[17:16], 14'h1A5A};
  endfunction

  function automatic logic [15:0] dev_word(logic [17:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
  endfunction

  function automatic logic [15:0] ref_word(logic [17:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // External SRAM: stores while CS and WE are low, drives pads while CS and OE are low.
  bit          prev_we = 1, prev_oe = 1;
  int          we_run = 0;
  logic [17:0] prev_addr = '0;
  logic [15:0] prev_dout = '0;

  always @(negedge clk) begin
    if (!reset) begin
      chk("we_oe_exclusive", {63'd0, (WE | OE)}, 64'd1);
      if (!WE) chk("pins_stable_we_low", {address_pins, data_pins_out}, {prev_addr, prev_dout});
    end
    if (!WE && !CS) dev_mem[address_pins] = data_pins_out;
    if (!WE) begin
      if (prev_we) n_we_pulses++;
      we_run++;
    end else if (!prev_we) begin
      if (!abort && !reset) chk("we_pulse_len", 64'(we_run), 64'(WAIT));
      we_run = 0;
    end
    if (!OE && prev_oe) n_oe_falls++;
    prev_we   = WE;
    prev_oe   = OE;
    prev_addr = address_pins;
    prev_dout = data_pins_out;
    data_pins_in = (!CS && !OE) ? (pad_force ? pad_value : dev_word(address_pins)) : 16'h0000;
  end

  // Monitor: each completion (ready rising) retires one scoreboard entry.
  bit   prev_ready = 1;
  int   busy = 0;
  exp_t e;

  always @(negedge clk) begin
    if (reset) begin
      sbq.delete();
      busy = 0;
      prev_ready = 1;
    end else begin
      if (!bus.ready) begin
        busy++;
      end else begin
        chk("idle_strobes", {CS, OE, WE}, 3'b111);
        if (!prev_ready) begin
          if (sbq.size() == 0) begin
            chk("unexpected_op", 64'(busy), 64'd0);
          end else begin
            e = sbq.pop_front();
            if (e.is_write) begin
              chk("write_latency", 64'(busy), 64'(WAIT + 2));
              chk("write_stored", dev_word(e.addr), e.data);
            end else begin
              chk("read_latency", 64'(busy), 64'(WAIT));
              chk("read_data", bus.data_read, e.data);
            end
          end
          busy = 0;
        end
      end
      prev_ready = bus.ready;
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (bus.ready !== 1'b1 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_wait: got busy expected ready within 100 cycles");
    end
  endtask

  task automatic drive_req(input bit w, input bit r, input logic [17:0] a, input logic [15:0] d);
    bus.write      = w;
    bus.read       = r;
    bus.address    = a;
    bus.data_write = d;
    if (w) begin
      ref_mem[a] = d;
      sbq.push_back('{1'b1, a, d});
      exp_writes++;
    end else if (r) begin
      sbq.push_back('{1'b0, a, pad_force ? pad_value : ref_word(a)});
    end
  endtask

  task automatic issue(input bit w, input bit r, input logic [17:0] a, input logic [15:0] d);
    wait_idle();
    drive_req(w, r, a, d);
    @(posedge clk);
    #1;
    bus.write = 0;
    bus.read  = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int oe0;
    int t;
    bus.write = 0;
    bus.read = 0;
    bus.address = '0;
    bus.data_write = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("reset_strobes", {CS, OE, WE}, 3'b111);
    chk("reset_ready", bus.ready, 1'b1);
    chk("reset_data_read", bus.data_read, 16'h0000);
    chk("reset_pins", {address_pins, data_pins_out}, 34'd0);

    // Write 0xAAAA to 0 with the request held for three edges
    @(posedge clk);
    #1;
    drive_req(1, 0, 18'h00000, 16'hAAAA);
    @(posedge clk);
    @(negedge clk);
    chk("setup_data", data_pins_out, 16'hAAAA);
    chk("setup_addr", address_pins, 18'h00000);
    chk("setup_strobes", {CS, OE, WE, bus.ready}, 4'b0110);
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.write = 0;
    wait_idle();
    chk("single_write", 64'(n_we_pulses), 64'd1);

    // Read 0 with the pads forced to 0x0A0A
    pad_force = 1;
    pad_value = 16'h0A0A;
    oe0 = n_oe_falls;
    issue(0, 1, 18'h00000, 16'h0000);
    wait_idle();
    pad_force = 0;
    chk("read_oe_pulses", 64'(n_oe_falls - oe0), 64'd1);

    // Write and read together: write wins
    oe0 = n_oe_falls;
    issue(1, 1, 18'h3FFFF, 16'h1234);
    wait_idle();
    chk("both_addr", address_pins, 18'h3FFFF);
    chk("both_no_read", 64'(n_oe_falls - oe0), 64'd0);
    chk("both_data_read_kept", bus.data_read, 16'h0A0A);

    // Requests raised while busy are ignored
    issue(1, 0, 18'h00100, 16'hBEEF);
    oe0 = n_oe_falls;
    bus.write = 1;
    bus.read = 1;
    bus.address = 18'h3FFFF;
    bus.data_write = 16'hDEAD;
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.write = 0;
    bus.read = 0;
    wait_idle();
    chk("busy_addr_kept", address_pins, 18'h00100);
    chk("busy_data_kept", data_pins_out, 16'hBEEF);
    chk("busy_no_read", 64'(n_oe_falls - oe0), 64'd0);
    issue(0, 1, 18'h00100, 16'h0000);

    // Reset in the middle of the WE pulse
    issue(1, 0, 18'h00200, 16'h5555);
    t = 0;
    while (WE !== 1'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("we_fell", WE, 1'b0);
    abort = 1;
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_strobes", {CS, OE, WE}, 3'b111);
    chk("abort_data_read", bus.data_read, 16'h0000);
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("abort_ready", bus.ready, 1'b1);
    abort = 0;

    // Random traffic over a small address pool so reads hit earlier writes
    for (int i = 0; i < 60; i++) begin
      logic [17:0] a;
      logic [15:0] d;
      int          op;
      a  = {2'($urandom_range(0, 3)), 12'h000, 4'($urandom_range(0, 15))};
      d  = 16'($urandom);
      op = int'($urandom_range(0, 4));
      case (op)
        0, 1:    issue(1, 0, a, d);
        2, 3:    issue(0, 1, a, d);
        default: issue(1, 1, a, d);
      endcase
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("write_count", 64'(n_we_pulses), 64'(exp_writes));
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
